// File: rtl/cell_memory_server_pkg.sv
// Shared definitions for the cons-cell memory server: request opcodes and opcode helpers.
package cell_memory_server_pkg;

   typedef enum logic [1:0] {
      FUNC_NOP          = 2'b00,
      FUNC_GET_CONTENTS = 2'b01,
      FUNC_CONS         = 2'b10,
      FUNC_SET_CDR      = 2'b11
   } func_e;

   // Opcodes that must fetch the target cell before responding.
   function automatic logic needs_read(input func_e f);
      return (f == FUNC_GET_CONTENTS) || (f == FUNC_SET_CDR);
   endfunction

endpackage

// File: rtl/cell_memory_server_cell_ram.sv
// Single-port cell store: synchronous write, registered read-first output, contents not reset.
module cell_memory_server_cell_ram #(
   parameter int DATA_W = 20,
   parameter int DEPTH  = 1024,
   parameter int IDX_W  = 10
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_r [DEPTH];

   // Read-first port: rdata returns the word as it was before this cycle's write.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[addr] <= wdata;
      end
      rdata <= mem_r[addr];
   end

endmodule

// File: rtl/cell_memory_server.sv
// Responder for cons-cell requests: reads cells, allocates new cells, rewrites cdr fields.
module cell_memory_server
   import cell_memory_server_pkg::*;
#(
   parameter int ADDR_W     = 10,
   parameter int DEPTH      = 1024,
   parameter int FIRST_FREE = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  power,
   input  logic [1:0]            func,
   input  logic                  execute,
   input  logic [ADDR_W-1:0]     addr0,
   input  logic [ADDR_W-1:0]     addr1,
   output logic [ADDR_W-1:0]     addr_out,
   output logic [2*ADDR_W-1:0]   data_out,
   output logic                  is_ready,
   output logic                  busy,
   output logic                  oom
);

   localparam int DATA_W = 2 * ADDR_W;
   localparam int PTR_W  = ADDR_W + 1;
   localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] DEPTH_P      = PTR_W'(DEPTH);
   localparam logic [PTR_W-1:0] FIRST_FREE_P = PTR_W'(FIRST_FREE);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD_ISSUE = 3'd1,
      ST_RD_WAIT  = 3'd2,
      ST_WR_CDR   = 3'd3,
      ST_CONS_WR  = 3'd4,
      ST_RESP     = 3'd5
   } state_e;

   state_e              state_r, state_next_s;
   func_e               func_r;
   logic [ADDR_W-1:0]   addr0_r, addr1_r;
   logic [PTR_W-1:0]    free_ptr_r;
   logic                accept_s, addr_ok_s, has_free_s;
   logic                ram_we_s;
   logic [IDX_W-1:0]    ram_addr_s;
   logic [DATA_W-1:0]   ram_wdata_s, ram_rdata_s;
   logic                load_resp_s, alloc_s, refuse_s;
   logic [ADDR_W-1:0]   resp_addr_s;
   logic [DATA_W-1:0]   resp_data_s;
   logic [ADDR_W-1:0]   addr_out_r;
   logic [DATA_W-1:0]   data_out_r;
   logic                is_ready_r, busy_r, oom_r;

   assign accept_s   = execute & power & (func_e'(func) != FUNC_NOP);
   assign addr_ok_s  = ({1'b0, addr0_r} < DEPTH_P);
   assign has_free_s = (free_ptr_r < DEPTH_P);

   // FSM state register; reset abandons any operation in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state, RAM control and response selection.
   always_comb begin
      state_next_s = state_r;
      ram_we_s     = 1'b0;
      ram_addr_s   = addr0_r[IDX_W-1:0];
      ram_wdata_s  = {ram_rdata_s[DATA_W-1:ADDR_W], addr1_r};
      load_resp_s  = 1'b0;
      alloc_s      = 1'b0;
      refuse_s     = 1'b0;
      resp_addr_s  = addr0_r;
      resp_data_s  = {DATA_W{1'b0}};
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_next_s = needs_read(func_e'(func)) ? ST_RD_ISSUE : ST_CONS_WR;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_RD_ISSUE: begin
            state_next_s = ST_RD_WAIT;
         end
         ST_RD_WAIT: begin
            if (func_r == FUNC_SET_CDR) begin
               state_next_s = ST_WR_CDR;
            end else begin
               state_next_s = ST_RESP;
               load_resp_s  = 1'b1;
               resp_data_s  = addr_ok_s ? ram_rdata_s : {DATA_W{1'b0}};
            end
         end
         ST_WR_CDR: begin
            // Old car is still on rdata because the port is read-first.
            ram_we_s     = addr_ok_s;
            state_next_s = ST_RESP;
            load_resp_s  = 1'b1;
            resp_data_s  = addr_ok_s ? ram_wdata_s : {DATA_W{1'b0}};
         end
         ST_CONS_WR: begin
            ram_addr_s   = free_ptr_r[IDX_W-1:0];
            ram_wdata_s  = {addr0_r, addr1_r};
            state_next_s = ST_RESP;
            load_resp_s  = 1'b1;
            if (has_free_s) begin
               ram_we_s    = 1'b1;
               alloc_s     = 1'b1;
               resp_addr_s = free_ptr_r[ADDR_W-1:0];
               resp_data_s = {addr0_r, addr1_r};
            end else begin
               refuse_s    = 1'b1;
               resp_addr_s = {ADDR_W{1'b0}};
               resp_data_s = {DATA_W{1'b0}};
            end
         end
         ST_RESP: begin
            state_next_s = ST_IDLE;
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // Request capture, allocation pointer, and registered response outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         func_r     <= FUNC_NOP;
         addr0_r    <= {ADDR_W{1'b0}};
         addr1_r    <= {ADDR_W{1'b0}};
         free_ptr_r <= FIRST_FREE_P;
         addr_out_r <= {ADDR_W{1'b0}};
         data_out_r <= {DATA_W{1'b0}};
         is_ready_r <= 1'b0;
         busy_r     <= 1'b0;
         oom_r      <= 1'b0;
      end else begin
         is_ready_r <= load_resp_s;
         busy_r     <= (state_next_s != ST_IDLE);
         if ((state_r == ST_IDLE) && accept_s) begin
            func_r  <= func_e'(func);
            addr0_r <= addr0;
            addr1_r <= addr1;
         end
         if (load_resp_s) begin
            addr_out_r <= resp_addr_s;
            data_out_r <= resp_data_s;
         end
         if (alloc_s) begin
            free_ptr_r <= free_ptr_r + PTR_W'(1);
         end
         if (refuse_s) begin
            oom_r <= 1'b1;
         end
      end
   end

   cell_memory_server_cell_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we_s),
      .addr  (ram_addr_s),
      .wdata (ram_wdata_s),
      .rdata (ram_rdata_s)
   );

   assign addr_out = addr_out_r;
   assign data_out = data_out_r;
   assign is_ready = is_ready_r;
   assign busy     = busy_r;
   assign oom      = oom_r;

endmodule

// File: tb/tb_cell_memory_server.sv
// Directed bench for cell_memory_server: vector table for request/response pairs plus handshake corner cases.
module tb_cell_memory_server;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        power = 1'b1;
   logic        exec_a = 1'b0;
   logic        exec_b = 1'b0;
   logic [1:0]  func = 2'b00;
   logic [9:0]  addr0 = 10'd0;
   logic [9:0]  addr1 = 10'd0;

   logic [9:0]  addr_out_a, addr_out_b;
   logic [19:0] data_out_a, data_out_b;
   logic        is_ready_a, is_ready_b, busy_a, busy_b, oom_a, oom_b;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   // Instance A: small store for exhaustion; instance B: allocates from cell 4 to build the static cell.
   cell_memory_server #(.ADDR_W(10), .DEPTH(20), .FIRST_FREE(16)) dut (
      .clk(clk), .rst(rst), .power(power), .func(func), .execute(exec_a),
      .addr0(addr0), .addr1(addr1), .addr_out(addr_out_a), .data_out(data_out_a),
      .is_ready(is_ready_a), .busy(busy_a), .oom(oom_a)
   );

   cell_memory_server #(.ADDR_W(10), .DEPTH(20), .FIRST_FREE(4)) dut_b (
      .clk(clk), .rst(rst), .power(power), .func(func), .execute(exec_b),
      .addr0(addr0), .addr1(addr1), .addr_out(addr_out_b), .data_out(data_out_b),
      .is_ready(is_ready_b), .busy(busy_b), .oom(oom_b)
   );

   typedef struct {
      int         sel;
      logic [1:0] f;
      logic [9:0] a0;
      logic [9:0] a1;
      int         lat;
      logic [9:0] ea;
      logic [19:0] ed;
      logic       eo;
   } vec_t;

   vec_t vecs [15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic run_op(input vec_t v, input string tag);
      int   lat;
      logic rdy;
      @(negedge clk);
      func  = v.f;
      addr0 = v.a0;
      addr1 = v.a1;
      if (v.sel == 0) exec_a = 1'b1;
      else            exec_b = 1'b1;
      @(negedge clk);
      exec_a = 1'b0;
      exec_b = 1'b0;
      check({tag, "_busy"}, {31'd0, (v.sel == 0) ? busy_a : busy_b}, 32'd1);
      lat = 0;
      for (int c = 1; c <= 8; c++) begin
         if (c > 1) @(negedge clk);
         rdy = (v.sel == 0) ? is_ready_a : is_ready_b;
         if (rdy) begin
            lat = c;
            break;
         end
      end
      check({tag, "_latency"}, lat, v.lat);
      check({tag, "_addr_out"}, {22'd0, (v.sel == 0) ? addr_out_a : addr_out_b}, {22'd0, v.ea});
      check({tag, "_data_out"}, {12'd0, (v.sel == 0) ? data_out_a : data_out_b}, {12'd0, v.ed});
      check({tag, "_oom"}, {31'd0, (v.sel == 0) ? oom_a : oom_b}, {31'd0, v.eo});
      @(negedge clk);
      check({tag, "_ready_pulse"}, {31'd0, (v.sel == 0) ? is_ready_a : is_ready_b}, 32'd0);
      check({tag, "_busy_clear"}, {31'd0, (v.sel == 0) ? busy_a : busy_b}, 32'd0);
   endtask

   initial begin
      int cnt;

      vecs[0]  = '{1, 2'b10, 10'd7,  10'd0, 2, 10'd4,  20'h01C00, 1'b0};
      vecs[1]  = '{1, 2'b01, 10'd4,  10'd0, 3, 10'd4,  20'h01C00, 1'b0};
      vecs[2]  = '{0, 2'b10, 10'd5,  10'd6, 2, 10'd16, 20'h01406, 1'b0};
      vecs[3]  = '{0, 2'b10, 10'd5,  10'd6, 2, 10'd17, 20'h01406, 1'b0};
      vecs[4]  = '{0, 2'b01, 10'd17, 10'd0, 3, 10'd17, 20'h01406, 1'b0};
      vecs[5]  = '{0, 2'b11, 10'd16, 10'd9, 4, 10'd16, 20'h01409, 1'b0};
      vecs[6]  = '{0, 2'b01, 10'd16, 10'd0, 3, 10'd16, 20'h01409, 1'b0};
      vecs[7]  = '{0, 2'b01, 10'd25, 10'd0, 3, 10'd25, 20'h00000, 1'b0};
      vecs[8]  = '{0, 2'b11, 10'd30, 10'd3, 4, 10'd30, 20'h00000, 1'b0};
      vecs[9]  = '{0, 2'b10, 10'd1,  10'd2, 2, 10'd18, 20'h00402, 1'b0};
      vecs[10] = '{0, 2'b10, 10'd3,  10'd4, 2, 10'd19, 20'h00C04, 1'b0};
      vecs[11] = '{0, 2'b10, 10'd7,  10'd7, 2, 10'd0,  20'h00000, 1'b1};
      vecs[12] = '{0, 2'b01, 10'd19, 10'd0, 3, 10'd19, 20'h00C04, 1'b1};
      vecs[13] = '{0, 2'b10, 10'd2,  10'd2, 2, 10'd0,  20'h00000, 1'b1};
      vecs[14] = '{0, 2'b01, 10'd16, 10'd0, 3, 10'd16, 20'h01409, 1'b1};

      // Power-on reset
      #2 rst = 1'b0;
      #1;
      check("reset_addr_out", {22'd0, addr_out_a}, 32'd0);
      check("reset_data_out", {12'd0, data_out_a}, 32'd0);
      check("reset_is_ready", {31'd0, is_ready_a}, 32'd0);
      check("reset_busy", {31'd0, busy_a}, 32'd0);
      check("reset_oom", {31'd0, oom_a}, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 15; i++) begin
         run_op(vecs[i], $sformatf("vec%0d", i));
      end

      // Reset in the middle of a CONS: no response, everything back to reset values
      @(negedge clk);
      func = 2'b10; addr0 = 10'd1; addr1 = 10'd1; exec_a = 1'b1;
      @(negedge clk);
      exec_a = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("midrst_addr_out", {22'd0, addr_out_a}, 32'd0);
      check("midrst_data_out", {12'd0, data_out_a}, 32'd0);
      check("midrst_is_ready", {31'd0, is_ready_a}, 32'd0);
      check("midrst_busy", {31'd0, busy_a}, 32'd0);
      check("midrst_oom", {31'd0, oom_a}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      cnt = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (is_ready_a) cnt++;
      end
      check("midrst_no_response", cnt, 0);
      run_op('{0, 2'b10, 10'd5, 10'd6, 2, 10'd16, 20'h01406, 1'b0}, "after_reset_cons");

      // execute held high across busy periods: GET every 4 cycles
      @(negedge clk);
      func = 2'b01; addr0 = 10'd16; exec_a = 1'b1;
      cnt = 0;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         if (is_ready_a) cnt++;
         if (c == 10) exec_a = 1'b0;
      end
      check("held_exec_responses", cnt, 3);
      check("held_exec_data", {12'd0, data_out_a}, 32'h01406);

      // power=0 and NOP requests are ignored
      power = 1'b0; func = 2'b10; addr0 = 10'd9; exec_a = 1'b1;
      cnt = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (is_ready_a || busy_a) cnt++;
      end
      check("power_off_ignored", cnt, 0);
      power = 1'b1; func = 2'b00;
      cnt = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (is_ready_a || busy_a) cnt++;
      end
      check("nop_ignored", cnt, 0);
      exec_a = 1'b0;
      run_op('{0, 2'b10, 10'd8, 10'd8, 2, 10'd17, 20'h02008, 1'b0}, "cons_after_ignored");

      // power drops right after acceptance: operation still completes
      @(negedge clk);
      func = 2'b01; addr0 = 10'd18; exec_a = 1'b1;
      @(negedge clk);
      exec_a = 1'b0; power = 1'b0;
      cnt = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (is_ready_a) cnt++;
      end
      check("power_drop_responses", cnt, 1);
      check("power_drop_addr", {22'd0, addr_out_a}, 32'd18);
      check("power_drop_data", {12'd0, data_out_a}, 32'h00402);
      power = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1);
   end

endmodule
